// File: rtl/util_rst_seq.sv
// util_rst_seq: reset sequencer for the root of a clock domain.
// It merges an external reset request, a PLL/MMCM locked flag and a soft-reset
// pulse. After a minimum quiet period it releases NUM_STAGES reset outputs one
// at a time, with STAGE_DELAY cycles between releases. Any new reset source
// reasserts every stage at once.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   S_ASSERT  | all stages asserted; waiting for HOLD_CYCLES quiet cycles
//   S_RELEASE | stage 0 released; releasing the rest every STAGE_DELAY
//   S_RUN     | all stages released; stays here until a source fires
module util_rst_seq #(
  parameter int unsigned NUM_STAGES   = 3,
  parameter int unsigned HOLD_CYCLES  = 16,
  parameter int unsigned STAGE_DELAY  = 8,
  parameter int unsigned SYNC_FF      = 2,
  parameter string       OUT_POLARITY = "ACTIVE_HIGH"
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ext_rst_in,
  input  logic                  locked,
  input  logic                  soft_rst,
  output logic [NUM_STAGES-1:0] rst_out,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned HW = $clog2(HOLD_CYCLES + 1);
  localparam int unsigned DW = $clog2(STAGE_DELAY + 1);
  localparam int unsigned SW = $clog2(NUM_STAGES + 1);

  localparam logic [HW-1:0] HOLD_TC = HW'(HOLD_CYCLES - 1);
  localparam logic [DW-1:0] DLY_TC  = DW'(STAGE_DELAY - 1);
  localparam logic [SW-1:0] LAST_IX = SW'(NUM_STAGES - 1);

  // Asserted level of a stage. The output register is kept in output
  // polarity so that rst_out comes straight from a flop.
  localparam logic ASRT = (OUT_POLARITY == "ACTIVE_LOW") ? 1'b0 : 1'b1;

  typedef enum logic [1:0] {
    S_ASSERT  = 2'd0,
    S_RELEASE = 2'd1,
    S_RUN     = 2'd2
  } state_t;

  state_t                r_state;
  logic [HW-1:0]         r_hold_cnt;
  logic [DW-1:0]         r_dly_cnt;
  logic [SW-1:0]         r_stage_idx;
  logic [NUM_STAGES-1:0] r_rst_out;
  logic                  r_busy;
  logic                  r_done;
  logic [SYNC_FF-1:0]    r_ext_sync;
  logic [SYNC_FF-1:0]    r_lock_sync;
  logic                  w_src_active;

  // Synchronizers. The presets make both async inputs read as "in reset"
  // until real samples have passed through the chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ext_sync  <= '1;
      r_lock_sync <= '0;
    end else begin
      r_ext_sync  <= {r_ext_sync[SYNC_FF-2:0], ext_rst_in};
      r_lock_sync <= {r_lock_sync[SYNC_FF-2:0], locked};
    end
  end

  assign w_src_active = r_ext_sync[SYNC_FF-1] | ~r_lock_sync[SYNC_FF-1] | soft_rst;

  // Sequencer FSM. Any active source overrides every state and every
  // scheduled release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_ASSERT;
      r_hold_cnt  <= '0;
      r_dly_cnt   <= '0;
      r_stage_idx <= '0;
      r_rst_out   <= {NUM_STAGES{ASRT}};
      r_busy      <= 1'b1;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_src_active) begin
        r_state     <= S_ASSERT;
        r_hold_cnt  <= '0;
        r_dly_cnt   <= '0;
        r_stage_idx <= '0;
        r_rst_out   <= {NUM_STAGES{ASRT}};
        r_busy      <= 1'b1;
      end else begin
        case (r_state)
          S_ASSERT: begin
            if (r_hold_cnt == HOLD_TC) begin
              r_hold_cnt   <= '0;
              r_rst_out[0] <= ~ASRT;
              if (NUM_STAGES == 1) begin
                r_state <= S_RUN;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end else begin
                r_state     <= S_RELEASE;
                r_stage_idx <= SW'(1);
                r_dly_cnt   <= '0;
              end
            end else begin
              r_hold_cnt <= r_hold_cnt + 1'b1;
            end
          end
          S_RELEASE: begin
            if (r_dly_cnt == DLY_TC) begin
              r_dly_cnt <= '0;
              for (int k = 0; k < NUM_STAGES; k++) begin
                if (r_stage_idx == SW'(k)) r_rst_out[k] <= ~ASRT;
              end
              if (r_stage_idx == LAST_IX) begin
                r_state <= S_RUN;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end else begin
                r_stage_idx <= r_stage_idx + 1'b1;
              end
            end else begin
              r_dly_cnt <= r_dly_cnt + 1'b1;
            end
          end
          S_RUN: begin
            r_busy <= 1'b0;
          end
          default: begin
            r_state <= S_ASSERT;
          end
        endcase
      end
    end
  end

  assign rst_out = r_rst_out;
  assign busy    = r_busy;
  assign done    = r_done;

endmodule

// File: tb/tb_util_rst_seq.sv
// Bench for util_rst_seq. Two instances share the stimulus: the default
// configuration and a one-stage active-low configuration. The reference model
// counts the unbroken run of quiet cycles each edge sees. From that count it
// derives how many stages should be released.
module tb_util_rst_seq;

  localparam int N1 = 3, H1 = 16, D1 = 8;
  localparam int N2 = 1, H2 = 1,  D2 = 1;
  localparam int SF = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ext_rst_in = 1'b0;
  logic       locked = 1'b0;
  logic       soft_rst = 1'b0;
  logic [2:0] rst_out_a;
  logic       busy_a, done_a;
  logic [0:0] rst_out_b;
  logic       busy_b, done_b;

  always #5 clk = ~clk;

  util_rst_seq #(
    .NUM_STAGES(N1), .HOLD_CYCLES(H1), .STAGE_DELAY(D1), .SYNC_FF(SF),
    .OUT_POLARITY("ACTIVE_HIGH")
  ) dut_a (
    .clk(clk), .rst(rst), .ext_rst_in(ext_rst_in), .locked(locked),
    .soft_rst(soft_rst), .rst_out(rst_out_a), .busy(busy_a), .done(done_a)
  );

  util_rst_seq #(
    .NUM_STAGES(N2), .HOLD_CYCLES(H2), .STAGE_DELAY(D2), .SYNC_FF(SF),
    .OUT_POLARITY("ACTIVE_LOW")
  ) dut_b (
    .clk(clk), .rst(rst), .ext_rst_in(ext_rst_in), .locked(locked),
    .soft_rst(soft_rst), .rst_out(rst_out_b), .busy(busy_b), .done(done_b)
  );

  typedef struct {
    int         tgt;
    logic [2:0] ra;
    logic       ba;
    logic       da;
    logic [0:0] rb;
    logic       bb;
    logic       db;
  } exp_t;

  exp_t sb[$];
  bit   ext_h[$];
  bit   lck_h[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   base    = 0;
  int   run_len = 0;
  bit   pu_phase = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm, logic [15:0] act, logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %0h, expected %0h", nm, cyc - base, act, exp);
    end
  endfunction

  function automatic int rel_cnt(int l, int h, int d, int n);
    int r;
    if (l < h) return 0;
    r = 1 + (l - h) / d;
    return (r > n) ? n : r;
  endfunction

  // Drive one interval of inputs and queue the response expected at the next edge.
  task automatic step(input bit e, input bit l, input bit s);
    exp_t       x;
    bit         ee, le, act;
    int         ra, rb;
    logic [2:0] all3;
    ext_rst_in = e;
    locked     = l;
    soft_rst   = s;
    ee = ext_h.pop_front();
    ext_h.push_back(e);
    le = lck_h.pop_front();
    lck_h.push_back(l);
    act = ee | ~le | s;
    run_len = act ? 0 : run_len + 1;
    ra   = rel_cnt(run_len, H1, D1, N1);
    rb   = rel_cnt(run_len, H2, D2, N2);
    all3 = 3'b111;
    x.tgt = cyc + 1;
    x.ra  = 3'(all3 << ra);
    x.ba  = (ra < N1);
    x.da  = (run_len == H1 + (N1 - 1) * D1);
    x.rb  = (rb == N2) ? 1'b1 : 1'b0;
    x.bb  = (rb < N2);
    x.db  = (run_len == H2 + (N2 - 1) * D2);
    sb.push_back(x);
    @(posedge clk);
    #1;
  endtask

  // Assert rst between clock edges, check the asynchronous response, and release it.
  task automatic do_reset();
    @(posedge clk);
    #3;
    rst = 1'b1;
    sb.delete();
    #1;
    chk("async_rst_out_a", 16'(rst_out_a), 16'h7);
    chk("async_busy_a",    16'(busy_a),    16'h1);
    chk("async_done_a",    16'(done_a),    16'h0);
    chk("async_rst_out_b", 16'(rst_out_b), 16'h0);
    chk("async_busy_b",    16'(busy_b),    16'h1);
    repeat (2) @(posedge clk);
    #1;
    rst  = 1'b0;
    base = cyc;
    ext_h.delete();
    lck_h.delete();
    for (int i = 0; i < SF; i++) begin
      ext_h.push_back(1'b1);
      lck_h.push_back(1'b0);
    end
    run_len = 0;
  endtask

  // Scoreboard monitor: pop and compare each expectation once its edge has passed.
  always @(negedge clk) begin
    exp_t x;
    if (sb.size() > 0 && sb[0].tgt == cyc) begin
      x = sb.pop_front();
      chk("rst_out_a", 16'(rst_out_a), 16'(x.ra));
      chk("busy_a",    16'(busy_a),    16'(x.ba));
      chk("done_a",    16'(done_a),    16'(x.da));
      chk("rst_out_b", 16'(rst_out_b), 16'(x.rb));
      chk("busy_b",    16'(busy_b),    16'(x.bb));
      chk("done_b",    16'(done_b),    16'(x.db));
    end
    if (pu_phase && !rst) begin
      case (cyc - base)
        2:  chk("pu_b_e2",   16'(rst_out_b), 16'h0);
        3:  begin
              chk("pu_b_e3",    16'(rst_out_b), 16'h1);
              chk("pu_b_done3", 16'(done_b),    16'h1);
            end
        17: chk("pu_a_e17",  16'(rst_out_a), 16'h7);
        18: chk("pu_a_e18",  16'(rst_out_a), 16'h6);
        25: chk("pu_a_e25",  16'(rst_out_a), 16'h6);
        26: chk("pu_a_e26",  16'(rst_out_a), 16'h4);
        33: begin
              chk("pu_a_e33",    16'(rst_out_a), 16'h4);
              chk("pu_a_done33", 16'(done_a),    16'h0);
            end
        34: begin
              chk("pu_a_e34",    16'(rst_out_a), 16'h0);
              chk("pu_a_done34", 16'(done_a),    16'h1);
              chk("pu_a_busy34", 16'(busy_a),    16'h0);
            end
        default: ;
      endcase
    end
  end

  int gap, len, kind;

  initial begin
    pu_phase = 1'b1;
    do_reset();
    repeat (40) step(1'b0, 1'b1, 1'b0);
    pu_phase = 1'b0;

    // soft reset from S_RUN
    step(1'b0, 1'b1, 1'b1);
    repeat (40) step(1'b0, 1'b1, 1'b0);

    // external reset arriving just after stage 0 releases
    step(1'b0, 1'b1, 1'b1);
    repeat (16) step(1'b0, 1'b1, 1'b0);
    repeat (3) step(1'b1, 1'b1, 1'b0);
    repeat (60) step(1'b0, 1'b1, 1'b0);

    // soft reset glitch during the hold period
    step(1'b0, 1'b1, 1'b1);
    repeat (10) step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    repeat (40) step(1'b0, 1'b1, 1'b0);

    // locked drops for one cycle in S_RUN
    step(1'b0, 1'b0, 1'b0);
    repeat (45) step(1'b0, 1'b1, 1'b0);

    // asynchronous reset while stages are being released
    step(1'b0, 1'b1, 1'b1);
    repeat (20) step(1'b0, 1'b1, 1'b0);
    do_reset();
    repeat (45) step(1'b0, 1'b1, 1'b0);

    // random mix of quiet gaps and reset-source bursts
    repeat (60) begin
      gap  = int'($urandom_range(0, 60));
      len  = int'($urandom_range(1, 4));
      kind = int'($urandom_range(0, 2));
      repeat (gap) step(1'b0, 1'b1, 1'b0);
      repeat (len) step(kind == 0, kind != 1, kind == 2);
    end
    repeat (60) step(1'b0, 1'b1, 1'b0);

    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: %0d entries left, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
